// File: rtl/bit_stream_serializer_pkg.sv
// ============================================================================
// Module   : bit_stream_serializer_pkg
// Brief    : Shared types and defaults for the bit stream serializer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bit_stream_serializer_pkg;

    localparam int c_DEFAULT_WIDTH   = 8;
    localparam int c_DEFAULT_COUNT_W = 8;
    localparam int c_DEFAULT_BCNT_W  = $clog2(c_DEFAULT_WIDTH);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Bit-counter width for a given word width; never narrower than one bit.
    function automatic int bcnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bit_stream_serializer_if.sv
// ============================================================================
// Module   : bit_stream_serializer_if
// Brief    : Load handshake and serial output bundle of the serializer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bit_stream_serializer_if
    import bit_stream_serializer_pkg::*;
#(
    parameter int WIDTH   = c_DEFAULT_WIDTH,
    parameter int COUNT_W = c_DEFAULT_COUNT_W
);

    logic [WIDTH-1:0]   load_data;
    logic               load_valid;
    logic               load_ready;
    logic               msb_first;
    logic               shift_en;
    logic               out_bit;
    logic               out_valid;
    logic               out_last;
    logic               busy;
    logic [COUNT_W-1:0] word_count;

    modport master (
        output load_data,
        output load_valid,
        output msb_first,
        output shift_en,
        input  load_ready,
        input  out_bit,
        input  out_valid,
        input  out_last,
        input  busy,
        input  word_count
    );

    modport slave (
        input  load_data,
        input  load_valid,
        input  msb_first,
        input  shift_en,
        output load_ready,
        output out_bit,
        output out_valid,
        output out_last,
        output busy,
        output word_count
    );

endinterface

`default_nettype wire

// File: rtl/bit_stream_serializer_ser_hold_buf.sv
// ============================================================================
// Module   : ser_hold_buf
// Brief    : One-word holding buffer (data, bit-order flag, full flag).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ser_hold_buf
    import bit_stream_serializer_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             i_load,
    input  wire logic [WIDTH-1:0] i_data,
    input  wire logic             i_msb,
    input  wire logic             i_pop,
    output logic      [WIDTH-1:0] o_data,
    output logic                  o_msb,
    output logic                  o_full
);

    logic [WIDTH-1:0] r_data;
    logic             r_msb;
    logic             r_full;

    // Load only ever happens while empty and pop only while full, so the
    // two controls never collide.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data <= '0;
            r_msb  <= 1'b0;
            r_full <= 1'b0;
        end else if (i_load) begin
            r_data <= i_data;
            r_msb  <= i_msb;
            r_full <= 1'b1;
        end else if (i_pop) begin
            r_full <= 1'b0;
        end
    end

    assign o_data = r_data;
    assign o_msb  = r_msb;
    assign o_full = r_full;

endmodule

`default_nettype wire

// File: rtl/bit_stream_serializer.sv
// ============================================================================
// Module   : bit_stream_serializer
// Brief    : Parallel-to-serial converter with gapless one-word look-ahead.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_stream_serializer
    import bit_stream_serializer_pkg::*;
#(
    parameter int WIDTH   = c_DEFAULT_WIDTH,
    parameter int COUNT_W = c_DEFAULT_COUNT_W
) (
    input  wire logic               clk,
    input  wire logic               reset,
    bit_stream_serializer_if.slave  bus
);

    localparam int               BCNT_W     = bcnt_width(WIDTH);
    localparam logic [BCNT_W-1:0] c_LAST_BIT = BCNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_sr;
    logic               r_sr_msb;
    logic [BCNT_W-1:0]  r_bcnt;
    logic [COUNT_W-1:0] r_word_count;

    logic [WIDTH-1:0]   w_hb_data;
    logic               w_hb_msb;
    logic               w_hb_full;

    logic               w_load_ready;
    logic               w_accept;
    logic               w_shifting;
    logic               w_on_last;
    logic               w_word_done;
    logic               w_load_direct;
    logic               w_hb_load;
    logic               w_hb_pop;

    logic               w_out_valid;
    logic               w_out_bit;
    logic               w_out_last;
    logic               w_busy;

    assign w_load_ready  = !w_hb_full;
    assign w_accept      = bus.load_valid && w_load_ready;
    assign w_shifting    = (r_state == SHIFT) && bus.shift_en;
    assign w_on_last     = (r_bcnt == c_LAST_BIT);
    assign w_word_done   = w_shifting && w_on_last;
    assign w_hb_pop      = w_word_done && w_hb_full;
    // A new word bypasses the buffer when the shift register is free now
    // or is being vacated at this edge with nothing already waiting.
    assign w_load_direct = w_accept && ((r_state == IDLE) || w_word_done);
    assign w_hb_load     = w_accept && !w_load_direct;

    ser_hold_buf #(
        .WIDTH (WIDTH)
    ) u_hold_buf (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_hb_load),
        .i_data (bus.load_data),
        .i_msb  (bus.msb_first),
        .i_pop  (w_hb_pop),
        .o_data (w_hb_data),
        .o_msb  (w_hb_msb),
        .o_full (w_hb_full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (w_word_done && !w_hb_full && !w_accept) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Serial output is forced low whenever no word is being presented.
    always_comb begin
        w_out_valid = (r_state == SHIFT);
        w_out_bit   = 1'b0;
        if (w_out_valid) begin
            w_out_bit = r_sr_msb ? r_sr[WIDTH-1] : r_sr[0];
        end
        w_out_last  = w_out_valid && w_on_last;
        w_busy      = w_out_valid || w_hb_full;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sr     <= '0;
            r_sr_msb <= 1'b0;
            r_bcnt   <= '0;
        end else if (w_load_direct) begin
            r_sr     <= bus.load_data;
            r_sr_msb <= bus.msb_first;
            r_bcnt   <= '0;
        end else if (w_hb_pop) begin
            r_sr     <= w_hb_data;
            r_sr_msb <= w_hb_msb;
            r_bcnt   <= '0;
        end else if (w_shifting && !w_on_last) begin
            if (r_sr_msb) begin
                r_sr <= {r_sr[WIDTH-2:0], 1'b0};
            end else begin
                r_sr <= {1'b0, r_sr[WIDTH-1:1]};
            end
            r_bcnt <= r_bcnt + BCNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_word_count <= '0;
        end else if (w_word_done) begin
            r_word_count <= r_word_count + COUNT_W'(1);
        end
    end

    assign bus.load_ready = w_load_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_bit    = w_out_bit;
    assign bus.out_last   = w_out_last;
    assign bus.busy       = w_busy;
    assign bus.word_count = r_word_count;

endmodule

`default_nettype wire

// File: tb/tb_bit_stream_serializer.sv
// ============================================================================
// Module   : tb_bit_stream_serializer
// Brief    : Self-checking bench: vector table, corner sequences, random run.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bit_stream_serializer;

    localparam int W  = 8;
    localparam int CW = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    bit_stream_serializer_if #(.WIDTH(W), .COUNT_W(CW)) bus ();

    bit_stream_serializer #(.WIDTH(W), .COUNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    logic [CW-1:0] exp_count;

    typedef struct {
        logic [W-1:0] data;
        logic         msb;
        logic [W-1:0] exp_seq;
    } vec_t;

    typedef struct {
        logic [W-1:0] d;
        logic         m;
    } word_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Offers one word, then records the W bits that follow with shift_en high.
    task automatic run_word(input logic [W-1:0] d, input logic m,
                            output logic [W-1:0] seq, output logic [W-1:0] lastv,
                            output int nvalid);
        int n;
        n = 0;
        bus.load_data  = d;
        bus.msb_first  = m;
        bus.load_valid = 1'b1;
        bus.shift_en   = 1'b1;
        while (bus.load_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", 32'(n < 40), 32'd1);
        @(negedge clk);
        bus.load_valid = 1'b0;
        bus.msb_first  = ~m;
        nvalid = 0;
        for (int i = 0; i < W; i++) begin
            seq[W-1-i]   = bus.out_bit;
            lastv[W-1-i] = bus.out_last;
            nvalid      += int'(bus.out_valid);
            @(negedge clk);
        end
    endtask

    initial begin
        vec_t         vecs[8];
        logic [W-1:0] seq;
        logic [W-1:0] lastv;
        int           nv;
        logic [15:0]  s16;
        int           vcnt;
        int           k;
        int           stalls;
        int           n;
        logic [1:0]   held;
        int           accepted;
        word_t        q[$];
        int           pos;
        logic [W-1:0] fd;
        logic         ev, eb, el, er, eby, acc;

        vecs[0] = '{8'hF8, 1'b1, 8'hF8};
        vecs[1] = '{8'hF8, 1'b0, 8'h1F};
        vecs[2] = '{8'hA5, 1'b1, 8'hA5};
        vecs[3] = '{8'h3C, 1'b0, 8'h3C};
        vecs[4] = '{8'h01, 1'b1, 8'h01};
        vecs[5] = '{8'h01, 1'b0, 8'h80};
        vecs[6] = '{8'h96, 1'b0, 8'h69};
        vecs[7] = '{8'h96, 1'b1, 8'h96};

        bus.load_data  = '0;
        bus.load_valid = 1'b0;
        bus.msb_first  = 1'b1;
        bus.shift_en   = 1'b0;

        // Reset state
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_ready", 32'(bus.load_ready), 32'd1);
        check("rst_busy",  32'(bus.busy), 32'd0);
        check("rst_count", 32'(bus.word_count), 32'd0);
        check("rst_bit",   32'(bus.out_bit), 32'd0);
        check("rst_last",  32'(bus.out_last), 32'd0);
        reset = 1'b1;
        exp_count = '0;
        bus.shift_en = 1'b1;
        vcnt = 0;
        repeat (3) begin
            @(negedge clk);
            vcnt += int'(bus.out_valid) + int'(bus.busy);
        end
        check("idle_after_rst", 32'(vcnt), 32'd0);

        // Table of single words
        for (int i = 0; i < 8; i++) begin
            run_word(vecs[i].data, vecs[i].msb, seq, lastv, nv);
            exp_count++;
            check($sformatf("vec%0d_seq", i), 32'(seq), 32'(vecs[i].exp_seq));
            check($sformatf("vec%0d_last", i), 32'(lastv), 32'h01);
            check($sformatf("vec%0d_valid", i), 32'(nv), 32'(W));
            check($sformatf("vec%0d_after", i), 32'(bus.out_valid), 32'd0);
            check($sformatf("vec%0d_count", i), 32'(bus.word_count), 32'(exp_count));
        end

        // Back-to-back words through the holding buffer
        bus.load_data  = 8'hF8;
        bus.msb_first  = 1'b1;
        bus.load_valid = 1'b1;
        bus.shift_en   = 1'b1;
        @(negedge clk);
        vcnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == 0) begin
                check("b2b_ready_first", 32'(bus.load_ready), 32'd1);
                bus.load_data = 8'h3C;
            end
            if (i == 1) begin
                check("b2b_ready_full", 32'(bus.load_ready), 32'd0);
                bus.load_valid = 1'b0;
            end
            if (i == 7) begin
                check("b2b_ready_last", 32'(bus.load_ready), 32'd0);
                check("b2b_last1", 32'(bus.out_last), 32'd1);
            end
            if (i == 8) begin
                check("b2b_ready_back", 32'(bus.load_ready), 32'd1);
                check("b2b_notlast", 32'(bus.out_last), 32'd0);
            end
            if (i == 15) check("b2b_last2", 32'(bus.out_last), 32'd1);
            s16[15-i] = bus.out_bit;
            vcnt += int'(bus.out_valid);
            @(negedge clk);
        end
        exp_count += 2;
        check("b2b_seq", 32'(s16), 32'hF83C);
        check("b2b_valid", 32'(vcnt), 32'd16);
        check("b2b_after", 32'(bus.out_valid), 32'd0);
        check("b2b_count", 32'(bus.word_count), 32'(exp_count));

        // Stall of three cycles while bit 2 is presented
        bus.load_data  = 8'hA5;
        bus.msb_first  = 1'b1;
        bus.load_valid = 1'b1;
        bus.shift_en   = 1'b1;
        @(negedge clk);
        bus.load_valid = 1'b0;
        k = 0; stalls = 0; n = 0; held = '0; seq = '0;
        while (k < W && n < 30) begin
            if (k == 2 && stalls < 3) begin
                bus.shift_en = 1'b0;
                if (stalls == 0) held = {bus.out_bit, bus.out_last};
                else check("stall_hold", 32'({bus.out_bit, bus.out_last}), 32'(held));
                stalls++;
            end else begin
                bus.shift_en = 1'b1;
                seq[W-1-k] = bus.out_bit;
                k++;
            end
            n++;
            @(negedge clk);
        end
        exp_count++;
        check("stall_seq", 32'(seq), 32'hA5);
        check("stall_after", 32'(bus.out_valid), 32'd0);
        check("stall_count", 32'(bus.word_count), 32'(exp_count));

        // Counter wrap: 255 streamed words, then one more
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        exp_count = '0;
        accepted = 0;
        n = 0;
        bus.shift_en = 1'b1;
        while ((accepted < 255 || bus.busy) && n < 3000) begin
            bus.load_valid = (accepted < 255);
            bus.load_data  = W'($urandom);
            bus.msb_first  = 1'($urandom);
            if (bus.load_valid && bus.load_ready) accepted++;
            n++;
            @(negedge clk);
        end
        bus.load_valid = 1'b0;
        check("wrap_wait", 32'(n < 3000), 32'd1);
        check("wrap_255", 32'(bus.word_count), 32'd255);
        run_word(8'h5A, 1'b1, seq, lastv, nv);
        check("wrap_seq", 32'(seq), 32'h5A);
        check("wrap_zero", 32'(bus.word_count), 32'd0);

        // Asynchronous reset mid-word with the holding buffer full
        bus.load_data  = 8'hF8;
        bus.msb_first  = 1'b1;
        bus.load_valid = 1'b1;
        bus.shift_en   = 1'b1;
        @(negedge clk);
        bus.load_data = 8'h3C;
        @(negedge clk);
        bus.load_valid = 1'b0;
        @(negedge clk);
        check("arst_pre_busy", 32'(bus.busy), 32'd1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_valid", 32'(bus.out_valid), 32'd0);
        check("arst_busy",  32'(bus.busy), 32'd0);
        check("arst_count", 32'(bus.word_count), 32'd0);
        check("arst_ready", 32'(bus.load_ready), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        run_word(8'h3C, 1'b1, seq, lastv, nv);
        check("arst_next_seq", 32'(seq), 32'h3C);
        check("arst_next_count", 32'(bus.word_count), 32'd1);

        // Randomized run against a queue-based reference model
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        exp_count = '0;
        pos = 0;
        q.delete();
        for (int c = 0; c < 1500; c++) begin
            bus.load_valid = 1'($urandom_range(0, 1));
            bus.load_data  = W'($urandom);
            bus.msb_first  = 1'($urandom);
            bus.shift_en   = ($urandom_range(0, 3) != 0);
            ev  = (q.size() > 0);
            eb  = 1'b0;
            if (ev) begin
                fd = q[0].d;
                eb = q[0].m ? fd[W-1-pos] : fd[pos];
            end
            el  = ev && (pos == W - 1);
            er  = (q.size() < 2);
            eby = ev;
            check("rand",
                  32'({bus.out_valid, bus.out_valid ? bus.out_bit : 1'b0, bus.out_last,
                       bus.load_ready, bus.busy, bus.word_count}),
                  32'({ev, eb, el, er, eby, exp_count}));
            acc = bus.load_valid && er;
            @(posedge clk);
            if (bus.shift_en && q.size() > 0) begin
                pos++;
                if (pos == W) begin
                    void'(q.pop_front());
                    pos = 0;
                    exp_count++;
                end
            end
            if (acc) q.push_back('{bus.load_data, bus.msb_first});
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
